// File: rtl/add_round_key_stage_pkg.sv
// Shared AES parameters and payload types for the AddRoundKey pipeline stage.
package add_round_key_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned ROUND_W    = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned NUM_COLS   = 4;

  typedef logic [NUM_COLS-1:0][DATA_WIDTH-1:0] state_cols_t;

  typedef struct packed {
    logic [ROUND_W-1:0] round;
    logic               last;
    state_cols_t        ark;
  } ark_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/add_round_key_stage_ark_xor.sv
// Combinational column select (MixColumns vs ShiftRows) followed by round-key XOR.
module ark_xor
  import add_round_key_stage_pkg::*;
(
  input  logic        sel_last,
  input  state_cols_t mc,
  input  state_cols_t sr,
  input  state_cols_t key,
  output state_cols_t ark_c
);

  always_comb begin
    ark_c = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      ark_c[i] = (sel_last ? sr[i] : mc[i]) ^ key[i];
    end
  end

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage with a two-entry skid buffer; in_ready is registered so
// out_ready never reaches the upstream handshake combinationally.
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = add_round_key_stage_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_mc0,
  input  logic [DATA_WIDTH-1:0] in_mc1,
  input  logic [DATA_WIDTH-1:0] in_mc2,
  input  logic [DATA_WIDTH-1:0] in_mc3,
  input  logic [DATA_WIDTH-1:0] in_sr0,
  input  logic [DATA_WIDTH-1:0] in_sr1,
  input  logic [DATA_WIDTH-1:0] in_sr2,
  input  logic [DATA_WIDTH-1:0] in_sr3,
  input  logic [DATA_WIDTH-1:0] in_key0,
  input  logic [DATA_WIDTH-1:0] in_key1,
  input  logic [DATA_WIDTH-1:0] in_key2,
  input  logic [DATA_WIDTH-1:0] in_key3,
  input  logic [ROUND_W-1:0]    in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_ark0,
  output logic [DATA_WIDTH-1:0] out_ark1,
  output logic [DATA_WIDTH-1:0] out_ark2,
  output logic [DATA_WIDTH-1:0] out_ark3,
  output logic [ROUND_W-1:0]    out_round,
  output logic                  out_last
);

  skid_state_e state_q, state_d;
  logic        in_ready_q;
  logic        out_valid_q;
  ark_entry_t  main_q, skid_q;
  ark_entry_t  new_entry;
  state_cols_t ark_c;
  logic        accept;
  logic        load_main_new, load_main_skid, load_skid;

  ark_xor u_ark_xor (
    .sel_last (in_last),
    .mc       ({in_mc3, in_mc2, in_mc1, in_mc0}),
    .sr       ({in_sr3, in_sr2, in_sr1, in_sr0}),
    .key      ({in_key3, in_key2, in_key1, in_key0}),
    .ark_c    (ark_c)
  );

  assign accept    = in_valid && in_ready_q;
  assign new_entry = '{round: in_round, last: in_last, ark: ark_c};

  // Next-state and register-load selection
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d       = ST_ONE;
          load_main_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_main_new) begin
        main_q <= new_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_entry;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ark0  = main_q.ark[0];
  assign out_ark1  = main_q.ark[1];
  assign out_ark2  = main_q.ark[2];
  assign out_ark3  = main_q.ark[3];
  assign out_round = main_q.round;
  assign out_last  = main_q.last;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: queue-based reference model plus directed
// FIPS-197 / backpressure / reset vectors and a randomized handshake run.
module tb_add_round_key_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned EW = 4 + 1 + 4 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_last;
  logic [W-1:0] in_mc0, in_mc1, in_mc2, in_mc3;
  logic [W-1:0] in_sr0, in_sr1, in_sr2, in_sr3;
  logic [W-1:0] in_key0, in_key1, in_key2, in_key3;
  logic [3:0]   in_round;
  logic         out_valid, out_ready, out_last;
  logic [W-1:0] out_ark0, out_ark1, out_ark2, out_ark3;
  logic [3:0]   out_round;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int delivered = 0;

  logic [EW-1:0] q[$];
  logic          up;
  logic          stalled_prev = 1'b0;
  logic          exp_rdy;
  logic [EW-1:0] prev_out;
  logic          rand_done;
  int            rounds[$];
  int            idx[$];

  add_round_key_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mc0(in_mc0), .in_mc1(in_mc1), .in_mc2(in_mc2), .in_mc3(in_mc3),
    .in_sr0(in_sr0), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_sr3(in_sr3),
    .in_key0(in_key0), .in_key1(in_key1), .in_key2(in_key2), .in_key3(in_key3),
    .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ark0(out_ark0), .out_ark1(out_ark1), .out_ark2(out_ark2), .out_ark3(out_ark3),
    .out_round(out_round), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] dut_out();
    return {out_round, out_last, out_ark0, out_ark1, out_ark2, out_ark3};
  endfunction

  // Reference: each accepted column set is (last ? sr : mc) ^ key, delivered FIFO order
  function automatic logic [EW-1:0] expect_entry();
    logic [W-1:0] c0, c1, c2, c3;
    c0 = (in_last ? in_sr0 : in_mc0) ^ in_key0;
    c1 = (in_last ? in_sr1 : in_mc1) ^ in_key1;
    c2 = (in_last ? in_sr2 : in_mc2) ^ in_key2;
    c3 = (in_last ? in_sr3 : in_mc3) ^ in_key3;
    return {in_round, in_last, c0, c1, c2, c3};
  endfunction

  // Upstream may hand over data from the first edge after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) up <= 1'b0;
    else        up <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled_prev = 1'b0;
      chk("rst_out_valid", EW'(out_valid), '0);
      chk("rst_in_ready", EW'(in_ready), '0);
      chk("rst_outputs", dut_out(), '0);
    end else begin
      exp_rdy = up && (q.size() < 2);
      chk("in_ready", EW'(in_ready), EW'(exp_rdy));
      chk("out_valid", EW'(out_valid), EW'(q.size() != 0));
      if (q.size() != 0) chk("out_entry", dut_out(), q[0]);
      if (stalled_prev) chk("stall_hold", dut_out(), prev_out);
      stalled_prev = out_valid && !out_ready;
      prev_out = dut_out();
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (in_valid && exp_rdy) begin
        q.push_back(expect_entry());
        accepted++;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] mc, input logic [127:0] sr, input logic [127:0] key,
                      input logic last, input logic [3:0] rnd);
    {in_mc0, in_mc1, in_mc2, in_mc3}     = mc;
    {in_sr0, in_sr1, in_sr2, in_sr3}     = sr;
    {in_key0, in_key1, in_key2, in_key3} = key;
    in_last  = last;
    in_round = rnd;
    in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sync();
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready stayed 0 expected 1 within 500 cycles");
    in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, del0;
    in_valid = 1'b0; in_last = 1'b0; in_round = '0; out_ready = 1'b0;
    {in_mc0, in_mc1, in_mc2, in_mc3} = '0;
    {in_sr0, in_sr1, in_sr2, in_sr3} = '0;
    {in_key0, in_key1, in_key2, in_key3} = '0;

    #3;
    chk("reset_valid", EW'(out_valid), '0);
    chk("reset_ready", EW'(in_ready), '0);
    chk("reset_ark0", EW'(out_ark0), '0);
    #19 rst_n = 1'b1;
    sync();
    chk("ready_after_reset", EW'(in_ready), EW'(1));

    // FIPS-197 round 1
    out_ready = 1'b1;
    send(128'h046681e5_e0cb199a_48f8d37a_2806264c, '0,
         128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0, 4'd1);
    @(negedge clk);
    chk("r1_valid", EW'(out_valid), EW'(1));
    chk("r1_ark", EW'({out_ark0, out_ark1, out_ark2, out_ark3}),
        EW'(128'ha49c7ff2_689f352b_6b5bea43_026a5049));
    chk("r1_round", EW'(out_round), EW'(1));

    // Final round selects ShiftRows columns
    sync();
    send({4{32'hffffffff}}, '0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b1, 4'd10);
    @(negedge clk);
    chk("final_ark", EW'({out_ark0, out_ark1, out_ark2, out_ark3}),
        EW'(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c));
    chk("final_last", EW'(out_last), EW'(1));

    // Backpressure fills both entries
    sync();
    out_ready = 1'b0;
    send(128'h00112233_44556677_8899aabb_ccddeeff, '0, {4{32'h0f0f0f0f}}, 1'b0, 4'd3);
    send('0, {4{32'hffffffff}}, 128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 4'd4);
    @(negedge clk);
    chk("bp_full_ready", EW'(in_ready), '0);
    chk("bp_hold_a", EW'({out_ark0, out_ark1, out_ark2, out_ark3}),
        EW'(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0));
    repeat (2) @(negedge clk);
    chk("bp_still_a", EW'(out_round), EW'(3));
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_deliver_a", EW'(out_round), EW'(3));
    @(negedge clk);
    chk("bp_deliver_b", EW'(out_round), EW'(4));
    chk("bp_ready_back", EW'(in_ready), EW'(1));
    @(negedge clk);
    chk("bp_drained", EW'(out_valid), '0);

    // Streaming, one per cycle
    sync();
    rounds.delete();
    idx.delete();
    fork
      begin
        for (int r = 1; r <= 10; r++) send(rnd128(), rnd128(), rnd128(), 1'b0, 4'(r));
      end
      begin
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          if (out_valid) begin
            rounds.push_back(int'(out_round));
            idx.push_back(n);
          end
        end
      end
    join
    chk("stream_count", EW'(rounds.size()), EW'(10));
    for (int i = 0; i < rounds.size(); i++) chk("stream_tag", EW'(rounds[i]), EW'(i + 1));
    if (idx.size() == 10) chk("stream_consecutive", EW'(idx[9] - idx[0]), EW'(9));

    // Asynchronous reset while full
    sync();
    out_ready = 1'b0;
    send(rnd128(), rnd128(), rnd128(), 1'b0, 4'd5);
    send(rnd128(), rnd128(), rnd128(), 1'b1, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", EW'(out_valid), '0);
    chk("async_ready", EW'(in_ready), '0);
    chk("async_outputs", dut_out(), '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("no_stale", EW'(out_valid), '0);
    end

    // Random handshakes
    sync();
    acc0 = accepted;
    del0 = delivered;
    rand_done = 1'b0;
    fork
      begin
        for (int e = 0; e < 1000; e++) begin
          int gap;
          gap = int'($urandom_range(0, 2));
          repeat (gap) sync();
          send(rnd128(), rnd128(), rnd128(), 1'($urandom_range(0, 1)),
               4'($urandom_range(1, 10)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("rand_drained", EW'(q.size()), '0);
    chk("rand_accepted", EW'(accepted - acc0), EW'(1000));
    chk("rand_delivered", EW'(delivered - del0), EW'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
